rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//  Round-robin arbiter that shares one resource (memory port, bus or register-file write port) among 8 requesters.
//  It registers a 3-bit grant code plus the matching one-hot select, holds the grant until the resource signals
//  completion, then advances priority. The one-hot select feeds the downstream enables directly.
// PARAMETERS
//  N_REQ    8   number of requesters; fixed at 8 (3-bit code space)
//  CODE_W   3   grant code width, $clog2(N_REQ)
//  TIMEOUT  16  max cycles a grant is held in BUSY (used only with ARB_TIMEOUT_EN), range 2..255
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  req         in   8       request vector, bit i = requester i; level, held until served
//  done        in   1       resource completion pulse for the current owner
//  gnt_valid   out  1       a grant is active (registered)
//  gnt_code    out  3       index of the current owner (registered)
//  gnt_onehot  out  8       1<<gnt_code when gnt_valid, else 8'h00
//  busy        out  1       FSM in BUSY (== gnt_valid)
//  timeout     out  1       1-cycle pulse on a forced release (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, ptr=0, gnt_valid=0, gnt_code=0, gnt_onehot=0, busy=0, timeout=0, wdog=0.
//  States: IDLE, BUSY.
//  IDLE: if req!=0, select the first set bit scanning ptr, ptr+1, .. wrapping mod 8. Next edge: state=BUSY,
//   gnt_code=winner, gnt_valid=1. Request->grant latency = 1 cycle. If req==0, stay IDLE.
//  BUSY: outputs hold stable. Release when (done==1) OR (req[gnt_code]==0) [OR wdog==TIMEOUT-1 with
//   ARB_TIMEOUT_EN]. At release edge: state=IDLE, gnt_valid=0, ptr=(gnt_code+1) mod 8 (3-bit wrap, 7->0).
//   gnt_code keeps its last value while gnt_valid=0.
//  There is exactly one idle cycle between consecutive grants, so the minimum grant-to-grant period is 2 cycles.
//  A done input while in IDLE is ignored. Changes to req bits other than the owner's during BUSY are ignored.
//  Simultaneous done and owner-drop count as a single release, with the same ptr update.
//  Fairness: a requester that holds req continuously is granted within 8 grants.
//  gnt_onehot is decoded combinationally from the registered gnt_code and gnt_valid (no extra latency).
//  A reset asserted mid-grant wins over everything: the next edge gives reset values, and any pending done is dropped.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: 8-bit wdog clears on entry to BUSY and increments each BUSY cycle.
//   At wdog==TIMEOUT-1, a forced release happens at the next edge (same ptr update) and timeout pulses high
//   for 1 cycle, coincident with gnt_valid falling. If done and the limit hit in the same cycle, it is a normal
//   release with timeout=0.
//  ARB_TIMEOUT_EN undefined: no wdog logic; timeout is tied to 0; a grant is held indefinitely until done or owner drop.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req=8'hFF -> all outputs 0; after release, the first grant is gnt_code=0 one cycle later.
//  2 Rotation: req=8'hFF held, done pulsed each BUSY cycle -> gnt_code sequence 0,1,..,7,0, one grant per 2 cycles.
//  3 Wrap/skip: ptr=6, req=8'b0000_0101 -> gnt_code=0, then ptr=1 -> next gnt_code=2, gnt_onehot=8'h04.
//  4 Owner drop: grant to 3, req[3] falls with done=0 -> gnt_valid=0 next edge, and the next winner is searched from 4.
//  5 Reset mid-grant: rst=1 during BUSY with done=1 -> reset values next edge, ptr=0, no spurious grant.
//  6 (ARB_TIMEOUT_EN, TIMEOUT=16) owner 5 holds req with no done -> release after 16 BUSY cycles, timeout=1
//    for 1 cycle, next grant goes to 6 if it requests.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with registered grant code and one-hot select
// Define ARB_TIMEOUT_EN to add a watchdog that force-releases a grant after TIMEOUT busy cycles.
module rr_arbiter_8 #(
   parameter int N_REQ  = 8,
   parameter int CODE_W = $clog2(N_REQ)
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic              done,
   output logic              gnt_valid,
   output logic [CODE_W-1:0] gnt_code,
   output logic [N_REQ-1:0]  gnt_onehot,
   output logic              busy,
   output logic              timeout
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] ptr_q, ptr_d;
   logic [CODE_W-1:0] gnt_code_q, gnt_code_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic [CODE_W-1:0] win_code, cand;
   logic              win_found;
   logic              normal_rel, forced_rel;

   // Scan from the highest offset down so the lowest offset from ptr wins last.
   always_comb begin
      win_found = 1'b0;
      win_code  = '0;
      cand      = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr_q + CODE_W'(i);
         if (req[cand]) begin
            win_found = 1'b1;
            win_code  = cand;
         end
      end
   end

   assign normal_rel = done || !req[gnt_code_q];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;
   logic       timeout_q, timeout_d;

   assign forced_rel = (wdog_q == 8'(TIMEOUT - 1));

   // A done or owner drop on the limit cycle is an ordinary release, so no pulse.
   always_comb begin
      wdog_d    = '0;
      timeout_d = 1'b0;
      if (state_q == BUSY) begin
         wdog_d    = wdog_q + 8'd1;
         timeout_d = forced_rel && !normal_rel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign forced_rel = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_code_d  = gnt_code_q;
      gnt_valid_d = gnt_valid_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d     = BUSY;
               gnt_code_d  = win_code;
               gnt_valid_d = 1'b1;
            end
         end
         BUSY: begin
            if (normal_rel || forced_rel) begin
               state_d     = IDLE;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_code_q + CODE_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_code_q  <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_code_q  <= gnt_code_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign gnt_valid  = gnt_valid_q;
   assign gnt_code   = gnt_code_q;
   assign busy       = (state_q == BUSY);
   assign gnt_onehot = gnt_valid_q ? (N_REQ'(1) << gnt_code_q) : '0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - table-driven bench for rr_arbiter_8
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic       gnt_valid;
   logic [2:0] gnt_code;
   logic [7:0] gnt_onehot;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rr_arbiter_8 dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .done       (done),
      .gnt_valid  (gnt_valid),
      .gnt_code   (gnt_code),
      .gnt_onehot (gnt_onehot),
      .busy       (busy),
      .timeout    (timeout)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic [7:0] exp_onehot;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [7:0] rq, input logic d,
                               input logic v, input logic [2:0] c);
      vec_t e;
      e.rst        = r;
      e.req        = rq;
      e.done       = d;
      e.exp_valid  = v;
      e.exp_code   = c;
      e.exp_onehot = v ? (8'h01 << c) : 8'h00;
      vecs.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] rq, input logic d);
      rst  = r;
      req  = rq;
      done = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic v, input logic [2:0] c, input logic t);
      logic [7:0] oh;
      oh = v ? (8'h01 << c) : 8'h00;
      check({tag, "_valid"}, 32'(gnt_valid), 32'(v));
      check({tag, "_code"}, 32'(gnt_code), 32'(c));
      check({tag, "_onehot"}, 32'(gnt_onehot), 32'(oh));
      check({tag, "_busy"}, 32'(busy), 32'(v));
      check({tag, "_timeout"}, 32'(timeout), 32'(t));
   endtask

   initial begin
      // reset held two cycles with all requests up
      add(1, 8'hFF, 0, 0, 0);
      add(1, 8'hFF, 0, 0, 0);
      add(0, 8'hFF, 0, 1, 0);
      // rotation with done held high: done in IDLE is ignored
      for (int k = 1; k <= 8; k++) begin
         add(0, 8'hFF, 1, 0, 3'((k - 1) % 8));
         add(0, 8'hFF, 1, 1, 3'(k % 8));
      end
      add(0, 8'hFF, 1, 0, 0);
      // wrap/skip from ptr=6
      add(0, 8'h20, 1, 1, 5);
      add(0, 8'h20, 1, 0, 5);
      add(0, 8'h05, 0, 1, 0);
      add(0, 8'h05, 1, 0, 0);
      add(0, 8'h05, 0, 1, 2);
      add(0, 8'h05, 1, 0, 2);
      // owner drop, non-owner changes ignored, done plus drop together
      add(0, 8'h08, 0, 1, 3);
      add(0, 8'h11, 0, 0, 3);
      add(0, 8'h11, 0, 1, 4);
      add(0, 8'h1F, 0, 1, 4);
      add(0, 8'h01, 1, 0, 4);
      add(0, 8'h21, 0, 1, 5);
      add(0, 8'h21, 1, 0, 5);
      // reset mid-grant with done pending
      add(0, 8'hFF, 0, 1, 6);
      add(1, 8'hFF, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0);
      add(0, 8'hFF, 0, 1, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("v%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_code", i), 32'(gnt_code), 32'(vecs[i].exp_code));
         check($sformatf("v%0d_onehot", i), 32'(gnt_onehot), 32'(vecs[i].exp_onehot));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
      end

`ifdef ARB_TIMEOUT_EN
      // owner 5 never completes: forced release after 16 busy cycles
      step(0, 8'h60, 1);
      check_all("to_rel0", 0, 0, 0);
      step(0, 8'h60, 0);
      check_all("to_grant5", 1, 5, 0);
      for (int c = 1; c < 16; c++) begin
         step(0, 8'h60, 0);
         check_all($sformatf("to_hold%0d", c), 1, 5, 0);
      end
      step(0, 8'h60, 0);
      check_all("to_fire", 0, 5, 1);
      step(0, 8'h60, 0);
      check_all("to_grant6", 1, 6, 0);
`else
      // without a watchdog the grant is held indefinitely
      for (int c = 0; c < 20; c++) begin
         step(0, 8'hFF, 0);
         check_all($sformatf("hold%0d", c), 1, 0, 0);
      end
      step(0, 8'hFF, 1);
      check_all("hold_rel", 0, 0, 0);
      step(0, 8'hFF, 0);
      check_all("hold_next", 1, 1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
